// File: rtl/inst_encoder_pkg.sv
// Shared field layout for the instruction encoder and decoder.
// Field positions, widths and the default opcode upper bits live here.
package inst_encoder_pkg;

  localparam int INST_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALU_W   = 4;
  localparam int OPC_W   = 3;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;
  localparam int ALU_LSB = 0;
  localparam int OPC_LSB = 4;

  localparam logic [OPC_W-1:0] OPC_HI_DEFAULT = 3'b011;

  // Simultaneous push/pop activity seen by the buffer in one cycle.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  // Pack the register/ALU fields into a word; unused bits stay zero.
  function automatic logic [INST_W-1:0] encode_inst(
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2,
    input logic [REG_W-1:0] rd,
    input logic [ALU_W-1:0] alu,
    input logic [OPC_W-1:0] opc
  );
    logic [INST_W-1:0] word;
    word = {INST_W{1'b0}};
    word[RS2_LSB +: REG_W] = rs2;
    word[RS1_LSB +: REG_W] = rs1;
    word[RD_LSB  +: REG_W] = rd;
    word[OPC_LSB +: OPC_W] = opc;
    word[ALU_LSB +: ALU_W] = alu;
    return word;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Valid/ready word buffer with a registered head output.
// The head register is refreshed on every push-into-empty or pop so it never reads storage combinationally.
module inst_fifo
  import inst_encoder_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [PTR_W-1:0] head_next_s;
  logic             push_s;
  logic             pop_s;
  fifo_op_e         op_s;

  assign in_ready    = (count_q < FULL_CNT);
  assign out_valid   = (count_q != {CNT_W{1'b0}});
  assign push_s      = in_valid & in_ready;
  assign pop_s       = out_valid & out_ready;
  assign op_s        = fifo_op_e'({push_s, pop_s});
  assign head_next_s = head_q + ONE_PTR;
  assign out_data    = data_q;
  assign count       = count_q;

  // Pointer, occupancy and head-register next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    data_d  = data_q;
    case (op_s)
      FIFO_PUSH: begin
        tail_d  = tail_q + ONE_PTR;
        count_d = count_q + ONE_CNT;
        if (count_q == {CNT_W{1'b0}}) begin
          data_d = in_data;
        end else begin
          data_d = data_q;
        end
      end
      FIFO_POP: begin
        head_d  = head_next_s;
        count_d = count_q - ONE_CNT;
        if (count_q > ONE_CNT) begin
          data_d = mem_q[head_next_s];
        end else begin
          data_d = data_q;
        end
      end
      FIFO_BOTH: begin
        head_d = head_next_s;
        tail_d = tail_q + ONE_PTR;
        // With a single entry the word being pushed becomes the new head.
        if (count_q == ONE_CNT) begin
          data_d = in_data;
        end else begin
          data_d = mem_q[head_next_s];
        end
      end
      default: begin
        head_d = head_q;
      end
    endcase
  end

  // Control state; storage itself is never cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      data_q  <= {WIDTH{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[tail_q] <= in_data;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Packs register/ALU fields into 32-bit instruction words and buffers them
// behind a valid/ready FIFO; also counts words handed downstream.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter  int               DEPTH  = 4,
  parameter  logic [OPC_W-1:0] OPC_HI = OPC_HI_DEFAULT,
  localparam int               CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  input  logic [REG_W-1:0]  rd,
  input  logic [ALU_W-1:0]  alu_control,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] inst,
  output logic [CNT_W-1:0]  count,
  output logic [15:0]       issued
);

  logic [INST_W-1:0] encoded_s;
  logic              out_valid_s;
  logic              pop_s;
  logic [15:0]       issued_q, issued_d;

  assign encoded_s = encode_inst(rs1, rs2, rd, alu_control, OPC_HI);

  inst_fifo #(
    .WIDTH (INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (encoded_s),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_data  (inst),
    .count     (count)
  );

  assign out_valid = out_valid_s;
  assign pop_s     = out_valid_s & out_ready;
  assign issued    = issued_q;

  // Issued counter wraps silently at 16 bits.
  always_comb begin
    issued_d = issued_q;
    if (pop_s) begin
      issued_d = issued_q + 16'd1;
    end else begin
      issued_d = issued_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= 16'd0;
    end else begin
      issued_q <= issued_d;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomised and directed bench for inst_encoder against a queue-based model.
module tb_inst_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_control;
  logic [31:0] inst;
  logic [2:0]  count;
  logic [15:0] issued;

  logic [31:0] exp_q[$];
  logic [15:0] exp_issued = 16'd0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  inst_encoder #(.DEPTH(DEPTH), .OPC_HI(3'b011)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready), .inst(inst),
    .count(count), .issued(issued)
  );

  function automatic logic [31:0] model_word(input logic [4:0] a1, input logic [4:0] a2,
                                             input logic [4:0] d, input logic [3:0] op);
    return (32'(a2) << 20) | (32'(a1) << 15) | (32'(d) << 7) | (32'd3 << 4) | 32'(op);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rand_fields();
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    rd = 5'($urandom);
    alu_control = 4'($urandom);
  endtask

  // Reference model: a plain queue of expected words plus a 16-bit pop counter.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_issued = 16'd0;
    end else begin
      bit do_pop, do_push;
      logic [31:0] w;
      do_pop = out_ready && (exp_q.size() != 0);
      do_push = in_valid && (exp_q.size() < DEPTH);
      w = model_word(rs1, rs2, rd, alu_control);
      if (do_pop) begin
        void'(exp_q.pop_front());
        exp_issued = exp_issued + 16'd1;
      end
      if (do_push) exp_q.push_back(w);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("issued", 32'(issued), 32'(exp_issued));
      if (exp_q.size() != 0) chk("inst", inst, exp_q[0]);
    end
  end

  initial begin
    int n;
    in_valid = 1'b0;
    out_ready = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; alu_control = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_issued", 32'(issued), 32'd0);
    chk("rst_inst", inst, 32'd0);

    // Single word, pushed at the very first edge after reset release.
    rst = 1'b0;
    in_valid = 1'b1;
    rs1 = 5'd3; rs2 = 5'd5; rd = 5'd7; alu_control = 4'h2;
    @(negedge clk);
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_inst", inst, 32'h005183B2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("single_issued", 32'(issued), 32'd1);

    // Fill, refuse a fifth push, then drain in order.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      rand_fields();
      if (i == 1) rd = 5'd0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
    chk("drain_issued", 32'(issued), 32'd5);
    chk("drain_count", 32'(count), 32'd0);

    // Simultaneous push and pop at count 2.
    in_valid = 1'b1;
    repeat (2) begin rand_fields(); @(negedge clk); end
    out_ready = 1'b1;
    rand_fields();
    @(negedge clk);
    chk("simul_count", 32'(count), 32'd2);
    chk("simul_issued", 32'(issued), 32'd6);

    // Full plus pop: push refused, count drops to 3.
    out_ready = 1'b0;
    repeat (2) begin rand_fields(); @(negedge clk); end
    chk("full_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    rand_fields();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("fullpop_count", 32'(count), 32'd3);
    chk("fullpop_issued", 32'(issued), 32'd7);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_issued", 32'(issued), 32'd0);
    @(negedge clk);
    chk("arst_inst", inst, 32'd0);
    rst = 1'b0;

    // Random traffic with varying push/pop bias.
    for (int i = 0; i < 1000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0) ^ (i >= 500);
      out_ready = ($urandom_range(0, 2) == 0) ^ (i >= 500);
      rand_fields();
      @(negedge clk);
    end

    // Stream until the issued counter reaches its top, then wrap it.
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (exp_issued != 16'hFFFF && n < 70000) begin
      rand_fields();
      @(negedge clk);
      n++;
    end
    chk("wrap_reached", 32'(n < 70000), 32'd1);
    chk("wrap_top", 32'(issued), 32'h0000FFFF);
    rand_fields();
    @(negedge clk);
    chk("wrap_zero", 32'(issued), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
